fc_sequencer: RTL
=================

FC_SEQUENCER -- requirements
Module: fc_sequencer

Interface
REQ-001 Parameter IN_N, default 64; number of binarized input features; a multiple of WORD_W.
REQ-002 Parameter WORD_W, default 16; weight word width in bits.
REQ-003 Parameter NCLS, default 10; number of output classes; at most 16.
REQ-004 Derived WPC = IN_N/WORD_W, the words per class; weight memory depth NCLS*WPC.
REQ-005 clk  in  1  clock, rising edge.
REQ-006 rstn  in  1  reset, asynchronous, active-low.
REQ-007 start  in  1  pulse; arms a new inference, honoured in IDLE only.
REQ-008 fbit  in  1  feature bit from the maxpool stage, 1 = +1, 0 = -1.
REQ-009 fbit_valid  in  1  fbit qualifier.
REQ-010 w_rd  out  1  weight read strobe.
REQ-011 w_addr  out  ceil(log2(NCLS*WPC))  weight word address.
REQ-012 w_data  in  WORD_W  weight word, valid exactly 1 cycle after w_rd; bit 1 = +1.
REQ-013 res_valid  out  1  per-class score pulse.
REQ-014 res_class  out  4  class index qualified by res_valid.
REQ-015 res_score  out  10 signed  class score qualified by res_valid.
REQ-016 class_idx  out  4  argmax result, held until the next done.
REQ-017 done  out  1  one-cycle pulse; class_idx is valid in the same cycle.
REQ-018 busy  out  1  high in LOAD and COMPUTE.
REQ-019 err_overrun  out  1  sticky flag for a dropped feature bit.

Function
REQ-020 FSM states: IDLE, LOAD, COMPUTE, FINISH.
- IDLE->LOAD on start.
- LOAD->COMPUTE on the cycle the IN_N-th bit is accepted.
- COMPUTE->FINISH after the last class score is emitted.
- FINISH->IDLE unconditionally after 1 cycle.
REQ-021 On entry to LOAD: feature bit count cleared, err_overrun cleared.
REQ-022 In LOAD, each fbit_valid cycle stores fbit at buf[count] and increments count; the first bit received lands at buf[0].
REQ-023 fbit_valid outside LOAD is dropped and sets err_overrun; the flag holds until the next accepted start or reset.
REQ-024 start outside IDLE is ignored; it has no effect on state, counters or outputs.
REQ-025 Weight reads, with T0 = the first COMPUTE cycle:
- w_rd high for exactly NCLS*WPC consecutive cycles starting at T0.
- w_addr = c*WPC+k at cycle T0+c*WPC+k.
- w_rd low in all other states.
REQ-026 Word k of class c pairs w_data[j] with buf[k*WORD_W+j]; the partial match count is popcount(XNOR) over WORD_W bits.
REQ-027 A per-class accumulator sums the matches over WPC words and resets at each class boundary.
- Score = 2*matches - IN_N, sign-extended to 10 bits; range -IN_N..+IN_N.
REQ-028 res_valid pulses at cycle T0+(c+1)*WPC+1 with res_class=c and res_score for that class.
- Exactly NCLS pulses per inference, classes in ascending order.
REQ-029 The argmax register compares each emitted score against the running best using signed strict greater-than.
- Ties resolve to the lowest index.
- Class 0 initialises the best unconditionally, so all-negative scores are handled correctly.
REQ-030 done pulses at cycle T0+NCLS*WPC+2 (FINISH); class_idx updates in that same cycle.
REQ-031 busy = (state==LOAD || state==COMPUTE).
REQ-032 Total latency from the last feature bit accepted to done is NCLS*WPC+2 cycles; with default parameters, 42 cycles.

Reset
REQ-033 When rstn is low, the block is in the following state:
- State is IDLE.
- w_rd=0, w_addr=0, res_valid=0, res_class=0, res_score=0.
- class_idx=0, done=0, busy=0, err_overrun=0.
- Feature buffer, count and accumulators are 0.
REQ-034 Reset asserted mid-LOAD or mid-COMPUTE aborts the inference immediately.
- No res_valid or done pulse follows.
- Normal operation resumes on the next start after rstn deasserts.

Verification (defaults: IN_N=64, WORD_W=16, NCLS=10)
REQ-035 Features all 1, all weight words 0xFFFF -> 10 pulses, each res_score=+64; class_idx=0; done exactly 42 cycles after the 64th bit.
REQ-036 Features all 1, class 3 words 0xFFFF, all other words 0x0000 -> class 3 scores +64, the rest -64; class_idx=3.
REQ-037 Features all 1, class 7 words FFFF,FFFF,0000,0000, all other words 0x0000 -> class 7 scores 0, the rest -64; class_idx=7.
REQ-038 fbit_valid pulsed during COMPUTE -> err_overrun=1 and stays set; scores and class_idx match the no-glitch run; the next start clears err_overrun.
REQ-039 rstn pulsed low at cycle T0+5 -> all outputs return to reset values; no done pulse; a following full inference completes correctly.
REQ-040 start pulsed during LOAD and during COMPUTE -> ignored; bit count, w_addr sequence and results are unchanged.

Source files
------------

// File: rtl/fc_sequencer_if.sv
// Bundle of the sequencer's feature, weight-memory and result signals.
//
// Valid semantics used throughout: fbit_valid, w_rd, res_valid and done are
// single-cycle qualifiers with no back-pressure. A qualified value is consumed
// at the rising edge that ends the cycle in which its qualifier is high.
// w_data answers w_rd exactly one cycle later. Nothing stalls.
interface fc_sequencer_if #(
    parameter int IN_N   = 64,
    parameter int WORD_W = 16,
    parameter int NCLS   = 10
);
    localparam int WPC = IN_N / WORD_W;
    localparam int TOT = NCLS * WPC;
    localparam int AW  = (TOT > 1) ? $clog2(TOT) : 1;

    logic                start;
    logic                fbit;
    logic                fbit_valid;
    logic                w_rd;
    logic [AW-1:0]       w_addr;
    logic [WORD_W-1:0]   w_data;
    logic                res_valid;
    logic [3:0]          res_class;
    logic signed [9:0]   res_score;
    logic [3:0]          class_idx;
    logic                done;
    logic                busy;
    logic                err_overrun;

    modport slave (
        input  start, fbit, fbit_valid, w_data,
        output w_rd, w_addr, res_valid, res_class, res_score,
               class_idx, done, busy, err_overrun
    );

    modport master (
        output start, fbit, fbit_valid, w_data,
        input  w_rd, w_addr, res_valid, res_class, res_score,
               class_idx, done, busy, err_overrun
    );
endinterface

// File: rtl/fc_sequencer.sv
// Binarized fully-connected layer sequencer: captures IN_N feature bits,
// streams NCLS*WPC weight words, scores every class with XNOR-popcount and
// reports the argmax class.
module fc_sequencer #(
    parameter int IN_N   = 64,
    parameter int WORD_W = 16,
    parameter int NCLS   = 10
) (
    input  logic            clk,
    input  logic            rstn,
    fc_sequencer_if.slave   bus,
    output logic [1:0]      state_dbg
);
    localparam int WPC = IN_N / WORD_W;
    localparam int TOT = NCLS * WPC;
    localparam int AW  = (TOT > 1) ? $clog2(TOT) : 1;
    localparam int IW  = (IN_N > 1) ? $clog2(IN_N) : 1;
    localparam int SW  = $clog2(IN_N + 1);
    localparam int RW  = $clog2(TOT + 1);
    localparam int KW  = (WPC > 1) ? $clog2(WPC) : 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_LOAD    = 2'd1;
    localparam logic [1:0] S_COMPUTE = 2'd2;
    localparam logic [1:0] S_FINISH  = 2'd3;

    logic [1:0]         state, state_nx;
    logic [IW-1:0]      fcnt;
    logic [IN_N-1:0]    fbuf;
    logic               err_r;
    logic [RW-1:0]      rd_cnt;
    logic [KW-1:0]      k_cnt;
    logic [3:0]         c_cnt;
    logic               d_vld;
    logic [KW-1:0]      d_k;
    logic [3:0]         d_c;
    logic [SW-1:0]      acc;
    logic               res_valid_r;
    logic [3:0]         res_class_r;
    logic signed [9:0]  res_score_r;
    logic signed [9:0]  best_score;
    logic [3:0]         best_idx;
    logic [3:0]         class_idx_r;

    logic               rd_active;
    logic               load_last;
    logic               last_res;
    logic               take_new;
    logic [3:0]         nxt_best_idx;
    logic [WORD_W-1:0]  fwords [WPC];
    logic [WORD_W-1:0]  fseg;
    logic [SW-1:0]      match_cnt;
    logic [SW-1:0]      sum;
    logic [15:0]        score_w;

    function automatic logic [SW-1:0] popcnt(input logic [WORD_W-1:0] v);
        logic [SW-1:0] n;
        n = '0;
        for (int i = 0; i < WORD_W; i++) n = n + SW'(v[i]);
        return n;
    endfunction

    // Feature buffer viewed as WPC words so word k lines up with weight word k.
    for (genvar g = 0; g < WPC; g++) begin : g_words
        assign fwords[g] = fbuf[g*WORD_W +: WORD_W];
    end

    // Datapath and control decodes.
    always_comb begin
        rd_active    = (state == S_COMPUTE) && (rd_cnt < RW'(TOT));
        load_last    = (state == S_LOAD) && bus.fbit_valid && (fcnt == IW'(IN_N - 1));
        last_res     = res_valid_r && (res_class_r == 4'(NCLS - 1));
        fseg         = fwords[d_k];
        match_cnt    = popcnt(~(bus.w_data ^ fseg));
        sum          = ((d_k == '0) ? '0 : acc) + match_cnt;
        score_w      = ({{(16-SW){1'b0}}, sum} << 1) - 16'(IN_N);
        // Class 0 always seeds the running best; later classes must beat it.
        take_new     = res_valid_r && ((res_class_r == 4'd0) || (res_score_r > best_score));
        nxt_best_idx = take_new ? res_class_r : best_idx;
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:    if (bus.start) state_nx = S_LOAD;
            S_LOAD:    if (load_last) state_nx = S_COMPUTE;
            S_COMPUTE: if (last_res)  state_nx = S_FINISH;
            default:   state_nx = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= S_IDLE;
        else       state <= state_nx;
    end

    // Feature capture and the sticky overrun flag for bits arriving outside LOAD.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fcnt  <= '0;
            fbuf  <= '0;
            err_r <= 1'b0;
        end else if (state == S_IDLE && bus.start) begin
            fcnt  <= '0;
            err_r <= 1'b0;
        end else if (bus.fbit_valid) begin
            if (state == S_LOAD) begin
                fbuf[fcnt] <= bus.fbit;
                fcnt       <= fcnt + 1'b1;
            end else begin
                err_r <= 1'b1;
            end
        end
    end

    // Weight address generation: one word per cycle from the first COMPUTE cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_cnt <= '0;
            k_cnt  <= '0;
            c_cnt  <= '0;
        end else if (state != S_COMPUTE) begin
            rd_cnt <= '0;
            k_cnt  <= '0;
            c_cnt  <= '0;
        end else if (rd_active) begin
            rd_cnt <= rd_cnt + 1'b1;
            if (k_cnt == KW'(WPC - 1)) begin
                k_cnt <= '0;
                c_cnt <= c_cnt + 1'b1;
            end else begin
                k_cnt <= k_cnt + 1'b1;
            end
        end
    end

    // Delay the read tags by one cycle to line up with the returning w_data.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            d_vld <= 1'b0;
            d_k   <= '0;
            d_c   <= '0;
        end else begin
            d_vld <= rd_active;
            d_k   <= k_cnt;
            d_c   <= c_cnt;
        end
    end

    // Per-class accumulation; the last word of a class emits its score.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc         <= '0;
            res_valid_r <= 1'b0;
            res_class_r <= '0;
            res_score_r <= '0;
        end else begin
            res_valid_r <= 1'b0;
            if (d_vld) begin
                acc <= sum;
                if (d_k == KW'(WPC - 1)) begin
                    res_valid_r <= 1'b1;
                    res_class_r <= d_c;
                    res_score_r <= score_w[9:0];
                end
            end
        end
    end

    // Running argmax; the result is published when the last score has been seen.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            best_score  <= '0;
            best_idx    <= '0;
            class_idx_r <= '0;
        end else begin
            if (take_new) begin
                best_score <= res_score_r;
                best_idx   <= res_class_r;
            end
            if (state == S_COMPUTE && last_res) class_idx_r <= nxt_best_idx;
        end
    end

    assign bus.w_rd        = rd_active;
    assign bus.w_addr      = rd_cnt[AW-1:0];
    assign bus.res_valid   = res_valid_r;
    assign bus.res_class   = res_class_r;
    assign bus.res_score   = res_score_r;
    assign bus.class_idx   = class_idx_r;
    assign bus.done        = (state == S_FINISH);
    assign bus.busy        = (state == S_LOAD) || (state == S_COMPUTE);
    assign bus.err_overrun = err_r;
    assign state_dbg       = state;
endmodule
